midi_note_parser: RTL

Converts a MIDI byte stream from the UART receiver into the monophonic `on` / `off` / `note` control signals the synthesizer consumes. Decodes Note On and Note Off messages on one selected channel and supports running status. Tracks the currently sounding note with last-note priority, so a stale release does not silence a newer note. Sits between the UART RX block and the synthesizer.

---
 rtl/midi_pkg.sv | 26 ++
 rtl/midi_note_parser.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and types for the MIDI note parser.
//   - MIDI status type nibbles (upper nibble of a status byte)
//   - lowest system real-time byte value
//   - parser FSM state encoding
package midi_pkg;

  // Status type nibbles
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // Bytes at or above this value are system real-time messages
  localparam logic [7:0] SYS_RT_MIN = 8'hF8;

  // Parser state: IDLE = no running status, D1/D2 = waiting for data byte 1/2
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D1   = 2'd1,
    D2   = 2'd2
  } state_e;

endpackage

// File: rtl/midi_note_parser.sv
// midi_note_parser: turns a MIDI byte stream into monophonic note control.
//   Decodes Note On / Note Off on one channel (or all, with OMNI), supports
//   running status, and tracks the sounding note with last-note priority.
// Parameters:
//   CHANNEL  MIDI channel matched against the status low nibble
//   OMNI     1 = accept every channel
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   rx_data   received MIDI byte
//   rx_valid  one-cycle strobe qualifying rx_data
//   on        one-cycle pulse: start note
//   off       one-cycle pulse: stop sounding note
//   note      current note number (valid when on pulses, held otherwise)
//   velocity  velocity of the last accepted Note On
//   active    high while a note is sounding
module midi_note_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       on,
  output logic       off,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       active
);

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       active_q, active_d;
  logic       on_q, on_d;
  logic       off_q, off_d;

  logic       is_rt_s;
  logic       is_sys_s;
  logic [3:0] st_type_s;
  logic       ours_s;
  logic       one_byte_s;

  // Classify the incoming byte and the latched running status
  always_comb begin
    is_rt_s    = (rx_data >= SYS_RT_MIN);
    is_sys_s   = (rx_data[7:4] == 4'hF) && !is_rt_s;
    st_type_s  = status_q[7:4];
    ours_s     = ((st_type_s == NOTE_OFF) || (st_type_s == NOTE_ON)) &&
                 ((OMNI == 1'b1) || (status_q[3:0] == CHANNEL));
    one_byte_s = (st_type_s == PROG) || (st_type_s == CHAN_AT);
  end

  // Next-state and message-completion logic
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    note_d   = note_q;
    vel_d    = vel_q;
    active_d = active_q;
    on_d     = 1'b0;
    off_d    = 1'b0;
    if (rx_valid && !is_rt_s) begin
      if (rx_data[7]) begin
        if (is_sys_s) begin
          // System common / SysEx kills running status; its data is dropped
          status_d = 8'h00;
          state_d  = IDLE;
        end else begin
          status_d = rx_data;
          state_d  = D1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          D1: begin
            if (one_byte_s) begin
              // Foreign one-byte message completes here; stay for running status
              state_d = D1;
            end else begin
              d1_d    = rx_data[6:0];
              state_d = D2;
            end
          end
          D2: begin
            state_d = D1;
            if (ours_s) begin
              if ((st_type_s == NOTE_ON) && (rx_data[6:0] != 7'd0)) begin
                note_d   = d1_q;
                vel_d    = rx_data[6:0];
                active_d = 1'b1;
                on_d     = 1'b1;
              end else if (active_q && (d1_q == note_q)) begin
                // Release only the note currently sounding
                active_d = 1'b0;
                off_d    = 1'b1;
              end else begin
                active_d = active_q;
              end
            end else begin
              state_d = D1;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= 8'h00;
      d1_q     <= 7'd0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      active_q <= 1'b0;
      on_q     <= 1'b0;
      off_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      active_q <= active_d;
      on_q     <= on_d;
      off_q    <= off_d;
    end
  end

  assign on       = on_q;
  assign off      = off_q;
  assign note     = note_q;
  assign velocity = vel_q;
  assign active   = active_q;

endmodule
